// File: rtl/lc_pkg.sv
// lc_pkg: shared definitions for the load-and-count sequencer.
//   lc_mode_e          : counting mode encodings (wrap / modulo / saturate / hold)
//   DIR_UP, DIR_DOWN   : count direction encodings
//   LC_DEFAULT_WIDTH   : default counter width
package lc_pkg;

   typedef enum logic [1:0] {
      LC_MODE_WRAP = 2'b00,
      LC_MODE_MOD  = 2'b01,
      LC_MODE_SAT  = 2'b10,
      LC_MODE_HOLD = 2'b11
   } lc_mode_e;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   localparam int LC_DEFAULT_WIDTH = 32;

endpackage

// File: rtl/lc_next_calc.sv
// lc_next_calc: purely combinational next-count and terminal-count generator.
// Ports:
//   out   in  WIDTH   current counter value
//   step  in  STEP_W  current step (zero-extended to WIDTH internally)
//   dir   in  1       0 = up, 1 = down
//   mode  in  2       wrap / modulo / saturate / hold
//   limit in  WIDTH   inclusive upper bound for modulo and saturate
//   nxt   out WIDTH   value the counter takes if it counts this edge
//   tc    out 1       a wrap or clamp happens on this update
module lc_next_calc
   import lc_pkg::*;
#(
   parameter int WIDTH  = LC_DEFAULT_WIDTH,
   parameter int STEP_W = 8
) (
   input  logic [WIDTH-1:0]  out,
   input  logic [STEP_W-1:0] step,
   input  logic              dir,
   input  logic [1:0]        mode,
   input  logic [WIDTH-1:0]  limit,
   output logic [WIDTH-1:0]  nxt,
   output logic              tc
);

   logic [WIDTH-1:0] step_x;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH:0]   limit_x;
   logic             borrow;
   lc_mode_e         m;

   // One extra bit on sum/diff carries the carry-out and the borrow.
   assign step_x  = WIDTH'(step);
   assign sum     = {1'b0, out} + {1'b0, step_x};
   assign diff    = {1'b0, out} - {1'b0, step_x};
   assign borrow  = diff[WIDTH];
   assign limit_x = {1'b0, limit};
   assign m       = lc_mode_e'(mode);

   always_comb begin
      nxt = out;
      tc  = 1'b0;
      // A zero step never moves the counter, whatever the mode.
      if (step_x != '0) begin
         case (m)
            LC_MODE_WRAP: begin
               if (dir == DIR_UP) begin
                  nxt = sum[WIDTH-1:0];
                  tc  = sum[WIDTH];
               end else begin
                  nxt = diff[WIDTH-1:0];
                  tc  = borrow;
               end
            end
            LC_MODE_MOD: begin
               if (dir == DIR_UP) begin
                  if (out > limit) begin
                     // Out of range (e.g. after a load): restart at the bottom.
                     nxt = '0;
                     tc  = 1'b1;
                  end else if (sum > limit_x) begin
                     nxt = WIDTH'(sum - limit_x - 1'b1);
                     tc  = 1'b1;
                  end else begin
                     nxt = sum[WIDTH-1:0];
                  end
               end else begin
                  if (out > limit) begin
                     nxt = limit;
                     tc  = 1'b1;
                  end else if (borrow) begin
                     // Wrap around the 0..limit ring by the leftover amount.
                     nxt = limit + 1'b1 - (step_x - out);
                     tc  = 1'b1;
                  end else begin
                     nxt = diff[WIDTH-1:0];
                  end
               end
            end
            LC_MODE_SAT: begin
               if (dir == DIR_UP) begin
                  if (sum >= limit_x) begin
                     nxt = limit;
                     tc  = (out != limit);
                  end else begin
                     nxt = sum[WIDTH-1:0];
                  end
               end else begin
                  if (out <= step_x) begin
                     nxt = '0;
                     tc  = (out != '0);
                  end else begin
                     nxt = diff[WIDTH-1:0];
                  end
               end
            end
            default: begin
               nxt = out;
               tc  = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/load_and_count_step.sv
// load_and_count_step: parametrised load-and-count sequencer with programmable
// step, up/down direction and wrap / modulo / saturate / hold modes.
// Optional feature: define LOAD_COUNT_CMP_EN to enable the registered compare
// output 'match'; otherwise match is tied 0 and cmp_val is ignored.
// Ports:
//   clk      in   1       clock, rising edge
//   reset_n  in   1       synchronous active-low reset
//   en       in   1       count enable
//   load     in   1       load d (beats en)
//   d        in   WIDTH   load value
//   step_wr  in   1       write step_in to the step register
//   step_in  in   STEP_W  new step
//   dir      in   1       0 = up, 1 = down
//   mode     in   2       00 wrap, 01 modulo, 10 saturate, 11 hold
//   limit    in   WIDTH   inclusive bound for modulo/saturate
//   cmp_val  in   WIDTH   compare value
//   out      out  WIDTH   counter value
//   step_out out  STEP_W  step register
//   tc       out  1       wrap/clamp pulse, aligned with out
//   match    out  1       out == cmp_val, aligned with out
module load_and_count_step
   import lc_pkg::*;
#(
   parameter int WIDTH        = LC_DEFAULT_WIDTH,
   parameter int STEP_W       = 8,
   parameter int DEFAULT_STEP = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              en,
   input  logic              load,
   input  logic [WIDTH-1:0]  d,
   input  logic              step_wr,
   input  logic [STEP_W-1:0] step_in,
   input  logic              dir,
   input  logic [1:0]        mode,
   input  logic [WIDTH-1:0]  limit,
   input  logic [WIDTH-1:0]  cmp_val,
   output logic [WIDTH-1:0]  out,
   output logic [STEP_W-1:0] step_out,
   output logic              tc,
   output logic              match
);

   logic [WIDTH-1:0] calc_nxt;
   logic             calc_tc;
   logic [WIDTH-1:0] out_nxt;
   logic             tc_nxt;

   lc_next_calc #(
      .WIDTH  (WIDTH),
      .STEP_W (STEP_W)
   ) u_calc (
      .out   (out),
      .step  (step_out),
      .dir   (dir),
      .mode  (mode),
      .limit (limit),
      .nxt   (calc_nxt),
      .tc    (calc_tc)
   );

   // Counter value that will be registered this edge (reset handled in the flop).
   always_comb begin
      out_nxt = out;
      tc_nxt  = 1'b0;
      if (load) begin
         out_nxt = d;
      end else if (en) begin
         out_nxt = calc_nxt;
         tc_nxt  = calc_tc;
      end
   end

   // The count above sees the current step_out, so a step write on the same
   // edge only affects later counts.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         out      <= '0;
         step_out <= STEP_W'(DEFAULT_STEP);
         tc       <= 1'b0;
      end else begin
         out <= out_nxt;
         tc  <= tc_nxt;
         if (step_wr) begin
            step_out <= step_in;
         end
      end
   end

`ifdef LOAD_COUNT_CMP_EN
   // Compare against the incoming value so match lines up with out.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         match <= 1'b0;
      end else begin
         match <= (out_nxt == cmp_val);
      end
   end
`else
   logic cmp_unused;
   assign cmp_unused = ^cmp_val;
   assign match      = 1'b0;
`endif

endmodule

// File: tb/tb_load_and_count_step.sv
module tb_load_and_count_step;
   import lc_pkg::*;

   localparam int W  = 32;
   localparam int SW = 8;
   localparam logic [W-1:0] CMP = 32'd8;

   logic          clk = 1'b0;
   logic          reset_n, en, load, step_wr, dir;
   logic [W-1:0]  d, limit, cmp_val;
   logic [SW-1:0] step_in;
   logic [1:0]    mode;
   logic [W-1:0]  out;
   logic [SW-1:0] step_out;
   logic          tc, match;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   load_and_count_step #(.WIDTH(W), .STEP_W(SW), .DEFAULT_STEP(4)) dut (
      .clk(clk), .reset_n(reset_n), .en(en), .load(load), .d(d),
      .step_wr(step_wr), .step_in(step_in), .dir(dir), .mode(mode),
      .limit(limit), .cmp_val(cmp_val), .out(out), .step_out(step_out),
      .tc(tc), .match(match)
   );

   typedef struct {
      logic          rst_n, en, load;
      logic [W-1:0]  d;
      logic          step_wr;
      logic [SW-1:0] step_in;
      logic          dir;
      logic [1:0]    mode;
      logic [W-1:0]  limit;
      logic [W-1:0]  exp_out;
      logic [SW-1:0] exp_step;
      logic          exp_tc;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(logic r, logic e, logic l, logic [W-1:0] dv,
                               logic sw, logic [SW-1:0] si, logic dr,
                               logic [1:0] md, logic [W-1:0] lim,
                               logic [W-1:0] eo, logic [SW-1:0] es, logic et);
      vec_t v;
      v = '{r, e, l, dv, sw, si, dr, md, lim, eo, es, et};
      tbl.push_back(v);
   endfunction

   function automatic logic exp_match(logic [W-1:0] o, logic rst);
`ifdef LOAD_COUNT_CMP_EN
      return rst && (o == CMP);
`else
      return 1'b0;
`endif
   endfunction

   task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(logic r, logic e, logic l, logic [W-1:0] dv, logic sw,
                        logic [SW-1:0] si, logic dr, logic [1:0] md,
                        logic [W-1:0] lim);
      reset_n = r; en = e; load = l; d = dv; step_wr = sw;
      step_in = si; dir = dr; mode = md; limit = lim;
      @(posedge clk);
      #1;
   endtask

   initial begin
      cmp_val = CMP;
      //   rst en ld d            swr sin dir  mode          lim  exp_out       step tc
      add(0, 1, 0, 0,            0, 0, DIR_UP,   LC_MODE_WRAP, 0,  0,            4, 0); // reset
      add(1, 1, 0, 0,            0, 0, DIR_UP,   LC_MODE_WRAP, 0,  4,            4, 0);
      add(1, 1, 0, 0,            0, 0, DIR_UP,   LC_MODE_WRAP, 0,  8,            4, 0);
      add(1, 1, 0, 0,            0, 0, DIR_UP,   LC_MODE_WRAP, 0,  12,           4, 0);
      add(1, 1, 1, 32'hFFFFFFFC, 0, 0, DIR_UP,   LC_MODE_WRAP, 0,  32'hFFFFFFFC, 4, 0); // load
      add(1, 1, 0, 0,            0, 0, DIR_UP,   LC_MODE_WRAP, 0,  0,            4, 1); // carry
      add(1, 0, 0, 0,            0, 0, DIR_UP,   LC_MODE_WRAP, 0,  0,            4, 0); // tc 1 cycle
      add(1, 0, 0, 0,            1, 3, DIR_UP,   LC_MODE_MOD,  9,  0,            3, 0);
      add(1, 1, 0, 0,            0, 0, DIR_UP,   LC_MODE_MOD,  9,  3,            3, 0);
      add(1, 1, 0, 0,            0, 0, DIR_UP,   LC_MODE_MOD,  9,  6,            3, 0);
      add(1, 1, 0, 0,            0, 0, DIR_UP,   LC_MODE_MOD,  9,  9,            3, 0);
      add(1, 1, 0, 0,            0, 0, DIR_UP,   LC_MODE_MOD,  9,  2,            3, 1);
      add(1, 1, 0, 0,            0, 0, DIR_DOWN, LC_MODE_MOD,  9,  9,            3, 1);
      add(1, 1, 0, 0,            0, 0, DIR_DOWN, LC_MODE_MOD,  9,  6,            3, 0);
      add(1, 0, 1, 0,            1, 4, DIR_UP,   LC_MODE_SAT,  10, 0,            4, 0);
      add(1, 1, 0, 0,            0, 0, DIR_UP,   LC_MODE_SAT,  10, 4,            4, 0);
      add(1, 1, 0, 0,            0, 0, DIR_UP,   LC_MODE_SAT,  10, 8,            4, 0);
      add(1, 1, 0, 0,            0, 0, DIR_UP,   LC_MODE_SAT,  10, 10,           4, 1);
      add(1, 1, 0, 0,            0, 0, DIR_UP,   LC_MODE_SAT,  10, 10,           4, 0);
      add(1, 0, 1, 3,            0, 0, DIR_DOWN, LC_MODE_SAT,  10, 3,            4, 0);
      add(1, 1, 0, 0,            0, 0, DIR_DOWN, LC_MODE_SAT,  10, 0,            4, 1);
      add(1, 1, 0, 0,            0, 0, DIR_DOWN, LC_MODE_SAT,  10, 0,            4, 0);
      add(1, 1, 1, 100,          1, 7, DIR_UP,   LC_MODE_WRAP, 0,  100,          7, 0); // load+en+step_wr
      add(1, 1, 0, 0,            0, 0, DIR_UP,   LC_MODE_WRAP, 0,  107,          7, 0);
      add(1, 1, 0, 0,            0, 0, DIR_UP,   LC_MODE_HOLD, 0,  107,          7, 0); // hold
      add(1, 1, 0, 0,            1, 0, DIR_UP,   LC_MODE_WRAP, 0,  114,          0, 0); // old step used
      add(1, 1, 0, 0,            0, 0, DIR_UP,   LC_MODE_WRAP, 0,  114,          0, 0); // step 0 holds
      add(1, 0, 1, 2,            1, 5, DIR_DOWN, LC_MODE_WRAP, 0,  2,            5, 0);
      add(1, 1, 0, 0,            0, 0, DIR_DOWN, LC_MODE_WRAP, 0,  32'hFFFFFFFD, 5, 1); // borrow
      add(1, 1, 0, 0,            0, 0, DIR_UP,   LC_MODE_MOD,  9,  0,            5, 1); // out>limit
      add(1, 1, 0, 0,            0, 0, DIR_DOWN, LC_MODE_MOD,  9,  5,            5, 1); // 0 down: 10-5

      foreach (tbl[i]) begin
         drive(tbl[i].rst_n, tbl[i].en, tbl[i].load, tbl[i].d, tbl[i].step_wr,
               tbl[i].step_in, tbl[i].dir, tbl[i].mode, tbl[i].limit);
         chk($sformatf("v%0d out", i),  out,           tbl[i].exp_out);
         chk($sformatf("v%0d step", i), W'(step_out),  W'(tbl[i].exp_step));
         chk($sformatf("v%0d tc", i),   W'(tc),        W'(tbl[i].exp_tc));
         chk($sformatf("v%0d match", i), W'(match),
             W'(exp_match(tbl[i].exp_out, tbl[i].rst_n)));
      end

      // Reset in the middle of a count, with a non-default step loaded.
      drive(1, 0, 1, 56, 1, 9, DIR_UP, LC_MODE_WRAP, 0);
      drive(1, 0, 0, 0,  1, 1, DIR_UP, LC_MODE_WRAP, 0);
      drive(1, 1, 0, 0,  0, 0, DIR_UP, LC_MODE_WRAP, 0);
      chk("pre-reset out", out, 57);
      drive(0, 1, 1, 99, 1, 9, DIR_UP, LC_MODE_WRAP, 0);
      chk("rst out",   out,          0);
      chk("rst step",  W'(step_out), 4);
      chk("rst tc",    W'(tc),       0);
      chk("rst match", W'(match),    0);
      drive(1, 1, 0, 0, 0, 0, DIR_UP, LC_MODE_WRAP, 0);
      chk("post-rst out", out, 4);
      drive(1, 1, 0, 0, 0, 0, DIR_UP, LC_MODE_WRAP, 0);
      chk("post-rst out2", out, 8);
      chk("post-rst match", W'(match), W'(exp_match(32'd8, 1'b1)));
      drive(1, 1, 0, 0, 0, 0, DIR_UP, LC_MODE_WRAP, 0);
      chk("match drops", W'(match), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
